// File: rtl/fifo_arb_pkg.sv
// Shared types, widths and helpers for the fifo_4x8 write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned MAX_N_REQ   = 4;
  localparam int unsigned BURST_CNT_W = 4;
  localparam int unsigned IDX_W       = $clog2(MAX_N_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Increment a requester index modulo n (n need not be a power of two).
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                input int unsigned     n);
    return ((32'(idx) + 32'd1) >= n) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set bit of req at or after start.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     winner_oh,
  output logic [IDX_W-1:0] winner_idx,
  output logic             any_valid
);

  int unsigned pos;

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    any_valid  = 1'b0;
    pos        = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(start) + k;
      if (pos >= N) pos = pos - N;
      for (int unsigned j = 0; j < N; j++) begin
        if (!any_valid && (pos == j) && req[j]) begin
          winner_oh[j] = 1'b1;
          winner_idx   = IDX_W'(j);
          any_valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the fifo_4x8 write port between N_REQ valid/ready
// producers, with bounded bursts per grant and FIFO-full backpressure.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [DATA_W-1:0]       fifo_data_in,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);

  localparam logic [BURST_CNT_W-1:0] LAST_BEAT = BURST_CNT_W'(MAX_BURST - 1);

  state_e                 state, state_n;
  logic [IDX_W-1:0]       owner, owner_n;
  logic [IDX_W-1:0]       last_owner, last_n;
  logic [N_REQ-1:0]       grant_n;
  logic [BURST_CNT_W-1:0] burst_cnt, cnt_n;

  logic                   own_valid;
  logic [DATA_W-1:0]      own_data;
  logic [IDX_W-1:0]       pick_start;
  logic [N_REQ-1:0]       pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   xfer;
  logic                   rel;

  // Select the current owner's valid and data.
  always_comb begin
    own_valid = 1'b0;
    own_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (32'(owner) == i) begin
        own_valid = req_valid[i];
        own_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Rotation starts after the owner while granted, after the last owner when idle;
  // either way the most recent owner ends up with lowest priority.
  assign pick_start = wrap_inc((state == GRANT) ? owner : last_owner, N_REQ);

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req        (req_valid),
    .start      (pick_start),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .any_valid  (pick_any)
  );

  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_n       = last_owner;
    grant_n      = grant;
    cnt_n        = burst_cnt;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_data_in = '0;
    xfer         = 1'b0;
    rel          = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_n = GRANT;
          owner_n = pick_idx;
          grant_n = pick_oh;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        req_ready    = fifo_full ? '0 : grant;
        fifo_wr_en   = own_valid & ~fifo_full;
        fifo_data_in = own_data;
        xfer         = own_valid & ~fifo_full;
        rel          = ~own_valid | (xfer & (burst_cnt == LAST_BEAT));
        if (xfer) cnt_n = burst_cnt + BURST_CNT_W'(1);
        if (rel) begin
          last_n = owner;
          cnt_n  = '0;
          if (pick_any) begin
            owner_n = pick_idx;
            grant_n = pick_oh;
          end else begin
            state_n = IDLE;
            grant_n = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(N_REQ - 1);
      grant      <= '0;
      busy       <= 1'b0;
      burst_cnt  <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_n;
      grant      <= grant_n;
      busy       <= (state_n == GRANT);
      burst_cnt  <= cnt_n;
    end
  end

endmodule
